hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Parametrised load-use hazard and pipeline-stall controller for the 5-stage core.
- Sits between ID decode and the pipeline registers and drives PC/IF-ID hold, ID/EX bubble insertion, IF/ID flush and a global memory freeze.
- Extends single-cycle load-use detection with:
  - configurable load latency (multi-cycle stall state machine)
  - N source operands
  - optional zero-register masking
  - branch flush priority
  - data-memory wait freeze
  - saturating stall performance counter

Parameters:
REG_ADDR_W, 5, register address width
NUM_SRC, 2, number of source operands compared in ID
LOAD_LAT, 1, total stall cycles per load-use hazard (>=1)
ZERO_REG_IGNORE, 1, 1 = register 0 never creates a hazard
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_src  in  NUM_SRC*REG_ADDR_W  packed ID source registers, src i at [i*REG_ADDR_W +: REG_ADDR_W]
id_src_valid  in  NUM_SRC  per-source "operand actually read" flags
id_ex_valid  in  1  ID/EX holds a real instruction (not a bubble)
id_ex_memread  in  1  instruction in ID/EX is a load
id_ex_write_reg  in  REG_ADDR_W  destination register of ID/EX instruction
branch_taken  in  1  taken branch/jump resolved in EX
mem_busy  in  1  data memory not ready this cycle
perf_clr  in  1  synchronous clear of stall_count
hold_pc  out  1  PC must not update
hold_if_id  out  1  IF/ID must not update
hold_control  out  1  zero control into ID/EX (insert bubble)
flush_if_id  out  1  invalidate IF/ID on next edge
freeze_pipe  out  1  hold every pipeline register (EX/MEM, MEM/WB included)
stall_active  out  1  FSM is in LOAD_STALL
stall_count  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset:
  - rst_n low -> state RUN, cnt=0, stall_count=0.
  - All outputs 0 while rst_n is low, regardless of inputs.
- Hazard detect (combinational):
  - hz = id_ex_valid & id_ex_memread & (any i: id_src_valid[i] & id_src[i]==id_ex_write_reg).
  - With ZERO_REG_IGNORE=1, id_ex_write_reg==0 forces hz=0.
- States: RUN, LOAD_STALL. Counter cnt is width clog2(LOAD_LAT+1).
- Priority within a cycle: mem_busy > branch_taken > load-use stall.
- mem_busy=1 (any state):
  - freeze_pipe=hold_pc=hold_if_id=1; hold_control=0; flush_if_id=0.
  - State, cnt and stall_count do not change.
  - A branch_taken asserted during mem_busy is not acted on until the first cycle with mem_busy=0.
- RUN, mem_busy=0:
  - branch_taken=1 -> flush_if_id=1, hold_control=1, hold_pc=0. A hz in the same cycle is ignored. Stay in RUN.
  - hz=1 -> hold_pc=hold_if_id=hold_control=1 in the same cycle (zero latency). stall_count += 1.
    - LOAD_LAT==1: stay in RUN.
    - LOAD_LAT>1: go to LOAD_STALL with cnt=LOAD_LAT-1.
  - Otherwise all outputs 0.
- LOAD_STALL, mem_busy=0:
  - hold_pc=hold_if_id=hold_control=1; stall_active=1; stall_count += 1.
  - cnt decrements each cycle. When cnt==1 this cycle, next state is RUN.
  - hz is not re-evaluated. The stall is unconditional for its remaining cycles.
  - branch_taken=1 -> abort: flush_if_id=1, hold_control=1, hold_pc=0, no count; next state RUN, cnt=0.
- Total load-use stall = exactly LOAD_LAT cycles in the absence of mem_busy. mem_busy cycles extend wall time without consuming cnt.
- stall_count:
  - Saturates at 2^CNT_W-1 (no wrap).
  - perf_clr has priority over increment: the next value is 0.
- Async reset mid-stall returns to RUN immediately. All holds drop in the same instant.

Test Plan:
- LOAD_LAT=1, id_ex_memread=1, id_ex_valid=1, write_reg=7, src0=7 valid -> hold_pc/hold_if_id/hold_control=1 for 1 cycle; stall_count=1.
- LOAD_LAT=3, same hazard -> holds high exactly 3 consecutive cycles; stall_active high cycles 2-3; stall_count=3; RUN afterwards.
- write_reg=0 with src1=0 valid, ZERO_REG_IGNORE=1 -> no hold. Same with src valid=0 and a matching address -> no hold.
- LOAD_LAT=3: hazard, then mem_busy=1 for 2 cycles during LOAD_STALL -> freeze_pipe=1 for those cycles. Load-use holds total 5 cycles. stall_count=3.
- branch_taken coincident with hz in RUN -> flush_if_id=1, hold_control=1, hold_pc=0; stall_count unchanged. branch_taken in LOAD_STALL -> abort to RUN next cycle.
- Force stall_count to 2^CNT_W-1 via repeated hazards (CNT_W=4) -> stays at 15. perf_clr together with a hazard -> 0. rst_n low mid-LOAD_STALL -> all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use hazard detection and pipeline stall/flush/freeze control
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W      = 5,
    parameter int NUM_SRC         = 2,
    parameter int LOAD_LAT        = 1,
    parameter int ZERO_REG_IGNORE = 1,
    parameter int CNT_W           = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_valid,
    input  logic                          id_ex_valid,
    input  logic                          id_ex_memread,
    input  logic [REG_ADDR_W-1:0]         id_ex_write_reg,
    input  logic                          branch_taken,
    input  logic                          mem_busy,
    input  logic                          perf_clr,
    output logic                          hold_pc,
    output logic                          hold_if_id,
    output logic                          hold_control,
    output logic                          flush_if_id,
    output logic                          freeze_pipe,
    output logic                          stall_active,
    output logic [CNT_W-1:0]              stall_count
);

    localparam int CW = $clog2(LOAD_LAT + 1);

    typedef enum logic {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic src_match, zero_masked, hz, inc;
    logic hold_pc_c, hold_if_id_c, hold_control_c, flush_if_id_c, freeze_pipe_c;

    always_comb begin
        src_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_valid[i] && (id_src[i*REG_ADDR_W +: REG_ADDR_W] == id_ex_write_reg)) begin
                src_match = 1'b1;
            end
        end
    end

    assign zero_masked = (ZERO_REG_IGNORE != 0) && (id_ex_write_reg == '0);
    assign hz          = id_ex_valid & id_ex_memread & src_match & ~zero_masked;

    // Priority: memory freeze, then branch flush, then load-use stall.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        inc            = 1'b0;
        hold_pc_c      = 1'b0;
        hold_if_id_c   = 1'b0;
        hold_control_c = 1'b0;
        flush_if_id_c  = 1'b0;
        freeze_pipe_c  = 1'b0;
        if (mem_busy) begin
            freeze_pipe_c = 1'b1;
            hold_pc_c     = 1'b1;
            hold_if_id_c  = 1'b1;
        end else if (state_q == RUN) begin
            if (branch_taken) begin
                flush_if_id_c  = 1'b1;
                hold_control_c = 1'b1;
            end else if (hz) begin
                hold_pc_c      = 1'b1;
                hold_if_id_c   = 1'b1;
                hold_control_c = 1'b1;
                inc            = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_d = LOAD_STALL;
                    cnt_d   = CW'(LOAD_LAT - 1);
                end
            end
        end else begin
            if (branch_taken) begin
                flush_if_id_c  = 1'b1;
                hold_control_c = 1'b1;
                state_d        = RUN;
                cnt_d          = '0;
            end else begin
                hold_pc_c      = 1'b1;
                hold_if_id_c   = 1'b1;
                hold_control_c = 1'b1;
                inc            = 1'b1;
                cnt_d          = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RUN;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (perf_clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    // Holds are combinational for zero-latency stalls, so gate them with reset directly.
    assign hold_pc      = hold_pc_c      & rst_n;
    assign hold_if_id   = hold_if_id_c   & rst_n;
    assign hold_control = hold_control_c & rst_n;
    assign flush_if_id  = flush_if_id_c  & rst_n;
    assign freeze_pipe  = freeze_pipe_c  & rst_n;
    assign stall_active = (state_q == LOAD_STALL) & rst_n;
    assign stall_count  = count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench driving LOAD_LAT=1 and LOAD_LAT=3 instances in parallel
module tb_hazard_stall_ctrl;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] LU   = 6'b111000;
    localparam logic [5:0] LS   = 6'b111001;
    localparam logic [5:0] BR   = 6'b001100;
    localparam logic [5:0] BRS  = 6'b001101;
    localparam logic [5:0] FZ   = 6'b110010;
    localparam logic [5:0] FZS  = 6'b110011;

    typedef struct {
        logic [5:0] e1;
        int         c1;
        logic [5:0] e3;
        int         c3;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] id_src;
    logic [1:0] id_src_valid;
    logic       id_ex_valid, id_ex_memread;
    logic [4:0] id_ex_write_reg;
    logic       branch_taken, mem_busy, perf_clr;

    logic        hp1, hi1, hc1, fl1, fz1, sa1;
    logic [3:0]  sc1;
    logic        hp3, hi3, hc3, fl3, fz3, sa3;
    logic [15:0] sc3;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG_IGNORE(1), .CNT_W(4)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_valid(id_src_valid),
        .id_ex_valid(id_ex_valid), .id_ex_memread(id_ex_memread), .id_ex_write_reg(id_ex_write_reg),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .perf_clr(perf_clr),
        .hold_pc(hp1), .hold_if_id(hi1), .hold_control(hc1), .flush_if_id(fl1),
        .freeze_pipe(fz1), .stall_active(sa1), .stall_count(sc1)
    );

    hazard_stall_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .ZERO_REG_IGNORE(1), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_valid(id_src_valid),
        .id_ex_valid(id_ex_valid), .id_ex_memread(id_ex_memread), .id_ex_write_reg(id_ex_write_reg),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .perf_clr(perf_clr),
        .hold_pc(hp3), .hold_if_id(hi3), .hold_control(hc3), .flush_if_id(fl3),
        .freeze_pipe(fz3), .stall_active(sa3), .stall_count(sc3)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // kind: 0 no hazard, 1 load-use on src0=r7, 2 r0 match (masked), 3 address match but src not read
    task automatic step(input logic rst, input int kind, input logic br, input logic busy, input logic clr,
                        input logic [5:0] e1, input int c1, input logic [5:0] e3, input int c3);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n           = rst;
        id_src          = {5'd3, 5'd7};
        id_src_valid    = 2'b01;
        id_ex_valid     = 1'b1;
        id_ex_memread   = 1'b1;
        id_ex_write_reg = 5'd7;
        case (kind)
            0: id_ex_write_reg = 5'd9;
            2: begin
                id_src          = {5'd0, 5'd4};
                id_src_valid    = 2'b10;
                id_ex_write_reg = 5'd0;
            end
            3: id_src_valid = 2'b00;
            default: ;
        endcase
        branch_taken = br;
        mem_busy     = busy;
        perf_clr     = clr;
        x.e1 = e1; x.c1 = c1; x.e3 = e3; x.c3 = c3;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            check("lat1_outputs", int'({hp1, hi1, hc1, fl1, fz1, sa1}), int'(e.e1));
            check("lat1_count",   int'(sc1), e.c1);
            check("lat3_outputs", int'({hp3, hi3, hc3, fl3, fz3, sa3}), int'(e.e3));
            check("lat3_count",   int'(sc3), e.c3);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        id_src = '0; id_src_valid = '0; id_ex_valid = 1'b0; id_ex_memread = 1'b0;
        id_ex_write_reg = '0; branch_taken = 1'b0; mem_busy = 1'b0; perf_clr = 1'b0;

        step(0, 1, 0, 0, 0, NONE, 0, NONE, 0);
        step(1, 0, 0, 0, 0, NONE, 0, NONE, 0);
        step(1, 1, 0, 0, 0, LU,   0, LU,   0);
        step(1, 0, 0, 0, 0, NONE, 1, LS,   1);
        step(1, 0, 0, 0, 0, NONE, 1, LS,   2);
        step(1, 0, 0, 0, 0, NONE, 1, NONE, 3);
        step(1, 2, 0, 0, 0, NONE, 1, NONE, 3);
        step(1, 3, 0, 0, 0, NONE, 1, NONE, 3);
        step(1, 1, 0, 0, 0, LU,   1, LU,   3);
        step(1, 0, 0, 1, 0, FZ,   2, FZS,  4);
        step(1, 0, 0, 1, 0, FZ,   2, FZS,  4);
        step(1, 0, 0, 0, 0, NONE, 2, LS,   4);
        step(1, 0, 0, 0, 0, NONE, 2, LS,   5);
        step(1, 0, 0, 0, 0, NONE, 2, NONE, 6);
        step(1, 1, 1, 0, 0, BR,   2, BR,   6);
        step(1, 0, 0, 0, 0, NONE, 2, NONE, 6);
        step(1, 1, 0, 0, 0, LU,   2, LU,   6);
        step(1, 0, 1, 0, 0, BR,   3, BRS,  7);
        step(1, 0, 0, 0, 0, NONE, 3, NONE, 7);
        step(1, 0, 1, 1, 0, FZ,   3, FZ,   7);
        step(1, 0, 1, 0, 0, BR,   3, BR,   7);
        step(1, 1, 0, 0, 0, LU,   3, LU,   7);
        step(0, 1, 0, 0, 0, NONE, 0, NONE, 0);
        step(1, 0, 0, 0, 0, NONE, 0, NONE, 0);
        for (int k = 0; k < 18; k++) begin
            step(1, 1, 0, 0, 0, LU, (k < 15) ? k : 15, (k % 3 == 0) ? LU : LS, k);
        end
        step(1, 1, 0, 0, 1, LU,   15, LU,   18);
        step(1, 0, 0, 0, 0, NONE, 0,  LS,   0);
        step(1, 0, 0, 0, 0, NONE, 0,  LS,   1);
        step(1, 0, 0, 0, 0, NONE, 0,  NONE, 2);

        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        if (q.size() > 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
